// File: rtl/squid_rs_pkg.sv
// rtl/squid_rs_pkg.sv - GF(16) symbol type, codeword geometry and constant multiplier
package squid_rs_pkg;

    localparam int SYM_W   = 4;
    localparam int NUM_SYM = 12;
    localparam int NUM_SYN = 4;
    localparam int NUM_VP  = 8;
    localparam int NUM_PP  = 4;

    typedef logic [SYM_W-1:0] sym_t;

    // alpha^n for n = 0..14, field generated by x^4 + x + 1
    localparam sym_t ALPHA_POW [15] = '{
        4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB,
        4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9
    };

    function automatic sym_t gf16_xtime(input sym_t a);
        return {a[2:0], 1'b0} ^ (a[3] ? 4'h3 : 4'h0);
    endfunction

    // Multiply by alpha^power; power is always an elaboration constant, so
    // this collapses to a fixed XOR network.
    function automatic sym_t gf16_mul_const(input sym_t sym, input int power);
        logic [3:0] idx;
        sym_t       coef;
        sym_t       acc;
        sym_t       t;
        idx  = 4'(power % 15);
        coef = ALPHA_POW[idx];
        acc  = '0;
        t    = sym;
        for (int i = 0; i < SYM_W; i++) begin
            if (coef[i]) begin
                acc = acc ^ t;
            end
            t = gf16_xtime(t);
        end
        return acc;
    endfunction

endpackage

// File: rtl/gf16_horner_cell.sv
// rtl/gf16_horner_cell.sv - one syndrome accumulator S_j with beat-wide Horner update
module gf16_horner_cell
    import squid_rs_pkg::*;
#(
    parameter int J   = 0,
    parameter int SPB = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clr,
    input  logic [SPB*SYM_W-1:0] sym,
    output logic [SYM_W-1:0]     s_next
);

    sym_t s_q;
    sym_t s_d;

    // Horner step: shift the running sum past one beat, then fold in this beat.
    always_comb begin
        sym_t acc;
        acc = clr ? '0 : gf16_mul_const(s_q, J * SPB);
        for (int k = 0; k < SPB; k++) begin
            acc = acc ^ gf16_mul_const(sym[k*SYM_W +: SYM_W], J * k);
        end
        s_next = acc;
        s_d    = en ? acc : s_q;
    end

    // Syndrome register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q <= '0;
        end else begin
            s_q <= s_d;
        end
    end

endmodule

// File: rtl/rs_burst_syndrome_accumulator.sv
// rtl/rs_burst_syndrome_accumulator.sv - burst codeword collector with incremental RS syndromes
module rs_burst_syndrome_accumulator
    import squid_rs_pkg::*;
#(
    parameter int SPB = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_first,
    input  logic [SPB*SYM_W-1:0]      in_sym,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_VP*SYM_W-1:0]   out_vp,
    output logic [NUM_PP*SYM_W-1:0]   out_pp,
    output logic [NUM_SYN*SYM_W-1:0]  out_syn,
    output logic                      out_err,
    output logic                      frame_err
);

    localparam int NB = NUM_SYM / SPB;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t                     state_q, state_d;
    logic [3:0]                 beat_cnt_q, beat_cnt_d;
    sym_t                       cw_q [NUM_SYM];
    sym_t                       cw_d [NUM_SYM];
    logic                       out_valid_q, out_valid_d;
    logic [NUM_VP*SYM_W-1:0]    vp_q, vp_d;
    logic [NUM_PP*SYM_W-1:0]    pp_q, pp_d;
    logic [NUM_SYN*SYM_W-1:0]   syn_q, syn_d;
    logic                       err_q, err_d;
    logic                       frame_err_q, frame_err_d;
    logic [NUM_SYN*SYM_W-1:0]   syn_next;

    logic accept, start, cont, stray, acc_en, final_beat, last_slot;
    int   base;

    // Handshake, framing decisions and beat-counter/state next values.
    always_comb begin
        last_slot   = (beat_cnt_q == 4'(NB - 1));
        // Only the beat that completes a codeword needs room in the output slot.
        in_ready    = !last_slot || !out_valid_q || out_ready;
        accept      = in_valid && in_ready;
        start       = accept && in_first;
        cont        = accept && !in_first && (state_q == ACCUM);
        stray       = accept && !in_first && (state_q == IDLE);
        acc_en      = start || cont;
        final_beat  = start ? (NB == 1) : (cont && last_slot);
        frame_err_d = stray || (start && (state_q == ACCUM));

        beat_cnt_d = beat_cnt_q;
        if (start) begin
            beat_cnt_d = (NB == 1) ? 4'd0 : 4'd1;
        end else if (cont) begin
            beat_cnt_d = last_slot ? 4'd0 : beat_cnt_q + 4'd1;
        end
        state_d = (beat_cnt_d == 4'd0) ? IDLE : ACCUM;
    end

    // Codeword buffer: highest indices arrive first, beat b lands at base..base+SPB-1.
    always_comb begin
        base = NUM_SYM - SPB * ((start ? 0 : int'(beat_cnt_q)) + 1);
        for (int i = 0; i < NUM_SYM; i++) begin
            cw_d[i] = cw_q[i];
            for (int k = 0; k < SPB; k++) begin
                if (acc_en && (base + k == i)) begin
                    cw_d[i] = in_sym[k*SYM_W +: SYM_W];
                end
            end
        end
    end

    // Output slot: load on completion, drain on consume, otherwise hold.
    always_comb begin
        out_valid_d = out_valid_q;
        vp_d        = vp_q;
        pp_d        = pp_q;
        syn_d       = syn_q;
        err_d       = err_q;
        if (final_beat) begin
            out_valid_d = 1'b1;
            for (int i = 0; i < NUM_VP; i++) begin
                vp_d[i*SYM_W +: SYM_W] = cw_d[i];
            end
            for (int i = 0; i < NUM_PP; i++) begin
                pp_d[i*SYM_W +: SYM_W] = cw_d[NUM_VP + i];
            end
            syn_d = syn_next;
            err_d = |syn_next;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    genvar j;
    generate
        for (j = 0; j < NUM_SYN; j++) begin : g_syn
            gf16_horner_cell #(
                .J   (j),
                .SPB (SPB)
            ) u_cell (
                .clk    (clk),
                .rst    (rst),
                .en     (acc_en),
                .clr    (start),
                .sym    (in_sym),
                .s_next (syn_next[j*SYM_W +: SYM_W])
            );
        end
    endgenerate

    // State, buffer and output slot registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            vp_q        <= '0;
            pp_q        <= '0;
            syn_q       <= '0;
            err_q       <= 1'b0;
            frame_err_q <= 1'b0;
            for (int i = 0; i < NUM_SYM; i++) begin
                cw_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            out_valid_q <= out_valid_d;
            vp_q        <= vp_d;
            pp_q        <= pp_d;
            syn_q       <= syn_d;
            err_q       <= err_d;
            frame_err_q <= frame_err_d;
            for (int i = 0; i < NUM_SYM; i++) begin
                cw_q[i] <= cw_d[i];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_vp    = vp_q;
    assign out_pp    = pp_q;
    assign out_syn   = syn_q;
    assign out_err   = err_q;
    assign frame_err = frame_err_q;

endmodule

// File: doc/rs_burst_syndrome_accumulator.md
Name: rs_burst_syndrome_accumulator

Overview:
- Upstream feeder of the second-level RS decoder: collects one 12-symbol GF(16) codeword (8 data symbols vp, 4 parity symbols pp) arriving over several beats of a memory burst.
- Computes the four syndromes incrementally with Horner accumulation, one beat per cycle.
- Presents vp, pp, syndromes and an error flag in a single registered output slot with valid/ready backpressure.

Parameters:
- SYM_W, 4: symbol width in bits; fixed at 4 (GF(2^4)).
- NUM_SYM, 12: symbols per codeword; indices 0..7 are vp[0..7], indices 8..11 are pp[0..3].
- NUM_SYN, 4: number of syndromes.
- SPB, 4: symbols per beat; legal values 1, 2, 3, 4, 6, 12 (must divide NUM_SYM). Beats per codeword NB = NUM_SYM/SPB.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid & in_ready.
- in_first  in  1  marks beat 0 of a codeword.
- in_sym  in  SPB x SYM_W  beat symbols; in_sym[k] is codeword index base+k.
- out_valid  out  1  output slot holds a complete codeword.
- out_ready  in  1  downstream consumes the slot when out_valid & out_ready.
- out_vp  out  8 x SYM_W  data symbols.
- out_pp  out  4 x SYM_W  parity symbols.
- out_syn  out  NUM_SYN x SYM_W  syndromes S0..S3.
- out_err  out  1  high when any syndrome is nonzero.
- frame_err  out  1  one-cycle pulse on a framing violation.

Behaviour:
- Field arithmetic:
  - GF(16) with primitive polynomial x^4+x+1; alpha = 4'h2.
  - S_j = sum over i of sym_i * alpha^(j*i), for j = 0..3.
  - All multiplies are by constants and are built from XOR networks.
- Beat order:
  - Beat b (0..NB-1) has base = NUM_SYM - SPB*(b+1), so the highest indices arrive first. With SPB=4: beat0 = pp[0..3], beat1 = vp[4..7], beat2 = vp[0..3].
- Accumulation on each accepted beat:
  - S_j <= (first ? 0 : S_j * alpha^(j*SPB)) XOR sum_k in_sym[k] * alpha^(j*k).
  - Symbols are written into the codeword buffer at indices base+k.
- Beat counter: beat_cnt, 0..NB-1.
  - Increments on each accepted beat.
  - Wraps to 0 after the last beat.
- State machine:
  - IDLE (beat_cnt=0, nothing accumulated).
  - ACCUM (0 < beat_cnt < NB).
  - The output slot is a separate register stage.
- Framing:
  - An accepted beat with in_first=1 while in ACCUM drops the partial codeword, restarts at beat 0 using this beat, and pulses frame_err for one cycle.
  - An accepted beat with in_first=0 in IDLE is discarded (beat_cnt stays 0) and pulses frame_err.
- Handshake:
  - in_ready = 1 for non-final beats.
  - For the final beat, in_ready = !out_valid | out_ready.
  - in_ready is combinational from out_valid/out_ready only and never depends on in_valid.
- Latency:
  - The final beat accepted at cycle T gives out_valid=1 at T+1, with out_vp/out_pp/out_syn/out_err updated together.
  - out_err = |S.
- Output slot:
  - Outputs are held stable while out_valid & !out_ready.
  - Consumption with no new completion gives out_valid=0 next cycle.
  - Simultaneous consumption and final-beat acceptance reloads the slot, keeping out_valid=1 with no bubble. Full throughput is one codeword per NB cycles.
- Reset (asynchronous, any time, including mid-codeword):
  - out_valid=0, out_err=0, frame_err=0.
  - out_vp/out_pp/out_syn all zero.
  - beat_cnt=0 and accumulators=0; any partial codeword is discarded.
  - in_ready=1 coming out of reset.
- in_valid=0 cycles inside a codeword are allowed: all state is held.

Decomposition:
- Shared package (squid_rs_pkg) holds:
  - the symbol typedef (logic [3:0]);
  - NUM_SYM, NUM_SYN, NUM_VP=8, NUM_PP=4;
  - the GF(16) alpha-power constant table;
  - the function gf16_mul_const(sym, power).
- One sub-module: gf16_horner_cell, one instance per syndrome j, holding the S_j register and its update logic.

Test Plan:
- Codeword all zeros, SPB=4, three back-to-back beats -> out_valid one cycle after beat 2; out_syn=[0,0,0,0], out_err=0.
- vp[0]=1, others 0 -> out_syn=[1,1,1,1], out_err=1; out_vp[0]=1.
- vp[1]=1 -> out_syn=[1,2,4,8]. pp[3]=1 (index 11) -> out_syn=[1,14,11,8].
- Backpressure: out_ready=0 for 5 cycles while the next codeword streams in:
  - beats 0 and 1 accepted;
  - in_ready=0 on beat 2 until out_ready=1;
  - outputs stable throughout;
  - the second codeword appears the cycle after.
- Framing:
  - in_first=1 on the second beat -> frame_err pulse, and the codeword is rebuilt from that beat; the result matches a clean 3-beat send.
  - A stray beat in IDLE with in_first=0 -> frame_err pulse and no output.
- Assert rst mid-codeword (after beat 1) -> out_valid=0 and all outputs 0 immediately; a fresh 3-beat codeword then decodes correctly.
